cascade_counter_chain: RTL and testbench

- Parametrised multi-stage ripple-carry counter: STAGE_COUNT digits, each with its own runtime maximum. Stage 0 is least significant.
- Generalises the single-digit cascade counter with up/down counting, parallel load, synchronous clear, a chain-wide terminal carry and a registered wrap pulse.
- Drives the HUB-75 scan hierarchy, e.g. column → row → bit-plane → frame, from one instance whose geometry comes from configuration registers.

---
 rtl/cascade_counter_chain_pkg.sv | 17 +
 rtl/cascade_counter_chain_stage.sv | 64 ++++++
 rtl/cascade_counter_chain.sv | 78 +++++++
 tb/tb_cascade_counter_chain.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cascade_counter_chain_pkg.sv
// Shared types and defaults for the cascade counter chain and its stages.
package cascade_counter_pkg;

  localparam int DEFAULT_STAGE_COUNT = 4;
  localparam int DEFAULT_STAGE_WIDTH = 8;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } direction_t;

  // Maps the raw down input onto the direction enum.
  function automatic direction_t to_direction(input logic down);
    return down ? DIR_DOWN : DIR_UP;
  endfunction

endpackage

// File: rtl/cascade_counter_chain_stage.sv
// One digit of the cascade counter chain.
// Counts up or down by one when carry_in is high, wrapping at its runtime
// maximum. A stage whose count sits above count_max is treated as terminal,
// so lowering the maximum at runtime never stalls the chain.
module cascade_counter_stage
  import cascade_counter_pkg::*;
#(
  parameter int STAGE_WIDTH = DEFAULT_STAGE_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   carry_in,
  input  logic                   down,
  input  logic                   clear,
  input  logic                   load,
  input  logic [STAGE_WIDTH-1:0] load_value,
  input  logic [STAGE_WIDTH-1:0] count_max,
  input  logic                   saturate_hold,
  output logic [STAGE_WIDTH-1:0] count,
  output logic                   is_zero,
  output logic                   is_max,
  output logic                   terminal,
  output logic                   carry_out
);

  typedef logic [STAGE_WIDTH-1:0] stage_count_t;

  stage_count_t count_q;
  stage_count_t count_d;
  direction_t   dir;

  assign dir       = to_direction(down);
  assign is_zero   = (count_q == '0);
  assign is_max    = (count_q >= count_max);
  assign terminal  = (dir == DIR_DOWN) ? is_zero : is_max;
  assign carry_out = carry_in & terminal;
  assign count     = count_q;

  // Next count: clear beats load beats a carried step; otherwise hold.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (carry_in && !saturate_hold) begin
      if (dir == DIR_DOWN) begin
        count_d = terminal ? count_max : (count_q - stage_count_t'(1));
      end else begin
        count_d = terminal ? '0 : (count_q + stage_count_t'(1));
      end
    end
  end

  // Count register with asynchronous reset to zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cascade_counter_chain.sv
// Multi-stage ripple-carry counter (stage 0 least significant) with up/down
// counting, parallel load, synchronous clear, chain-wide carry and a
// registered wrap pulse.
// Optional build macro CASCADE_COUNTER_CHAIN_SATURATE_EN: a step that would
// wrap the whole chain leaves every count unchanged instead.
// Interface: step is a single-cycle request with no back-pressure; every
// cycle with step high advances the chain exactly once (clear/load win).
module cascade_counter_chain
  import cascade_counter_pkg::*;
#(
  parameter int STAGE_COUNT = DEFAULT_STAGE_COUNT,
  parameter int STAGE_WIDTH = DEFAULT_STAGE_WIDTH
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               step,
  input  logic                               down,
  input  logic                               clear,
  input  logic                               load,
  input  logic [STAGE_COUNT*STAGE_WIDTH-1:0] load_value,
  input  logic [STAGE_COUNT*STAGE_WIDTH-1:0] count_max,
  output logic [STAGE_COUNT*STAGE_WIDTH-1:0] count,
  output logic [STAGE_COUNT-1:0]             is_zero,
  output logic [STAGE_COUNT-1:0]             is_max,
  output logic                               carry_out,
  output logic                               wrap_pulse
);

  // carry[i] is the carry into stage i; carry[STAGE_COUNT] leaves the chain.
  logic [STAGE_COUNT:0]   carry;
  logic [STAGE_COUNT-1:0] terminal;
  logic                   chain_wrap;
  logic                   saturate_hold;

  assign carry[0] = step;

  // A wrap needs every stage terminal. Computing it as a flat AND instead of
  // via the serial ripple keeps the hold path short; the two are equal.
  assign chain_wrap = step & (&terminal);
  assign carry_out  = carry[STAGE_COUNT];

`ifdef CASCADE_COUNTER_CHAIN_SATURATE_EN
  assign saturate_hold = chain_wrap;
`else
  assign saturate_hold = 1'b0;
`endif

  for (genvar i = 0; i < STAGE_COUNT; i++) begin : g_stage
    cascade_counter_stage #(
      .STAGE_WIDTH(STAGE_WIDTH)
    ) u_stage (
      .clock        (clock),
      .reset_n      (reset_n),
      .carry_in     (carry[i]),
      .down         (down),
      .clear        (clear),
      .load         (load),
      .load_value   (load_value[i*STAGE_WIDTH +: STAGE_WIDTH]),
      .count_max    (count_max[i*STAGE_WIDTH +: STAGE_WIDTH]),
      .saturate_hold(saturate_hold),
      .count        (count[i*STAGE_WIDTH +: STAGE_WIDTH]),
      .is_zero      (is_zero[i]),
      .is_max       (is_max[i]),
      .terminal     (terminal[i]),
      .carry_out    (carry[i+1])
    );
  end

  // One-cycle pulse after a step that wraps the chain, unless clear/load won.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= chain_wrap & ~clear & ~load;
    end
  end

endmodule

// File: tb/tb_cascade_counter_chain.sv
// Bench for cascade_counter_chain with 3 stages of 4 bits. A behavioural
// model tracks per-digit counts; expected next-cycle {wrap_pulse, count}
// values are queued and compared one cycle later.
module tb_cascade_counter_chain;

  localparam int SC = 3;
  localparam int SW = 4;
  localparam int CW = SC * SW;

`ifdef CASCADE_COUNTER_CHAIN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clock;
  logic          reset_n;
  logic          step;
  logic          down;
  logic          clear;
  logic          load;
  logic [CW-1:0] load_value;
  logic [CW-1:0] count_max;
  logic [CW-1:0] count;
  logic [SC-1:0] is_zero;
  logic [SC-1:0] is_max;
  logic          carry_out;
  logic          wrap_pulse;

  cascade_counter_chain #(
    .STAGE_COUNT(SC),
    .STAGE_WIDTH(SW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .step      (step),
    .down      (down),
    .clear     (clear),
    .load      (load),
    .load_value(load_value),
    .count_max (count_max),
    .count     (count),
    .is_zero   (is_zero),
    .is_max    (is_max),
    .carry_out (carry_out),
    .wrap_pulse(wrap_pulse)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt[SC];
  logic [CW:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int max_of(input int i);
    return int'(count_max[i*SW +: SW]);
  endfunction

  function automatic bit term_of(input int i);
    return down ? (m_cnt[i] == 0) : (m_cnt[i] >= max_of(i));
  endfunction

  function automatic logic [CW-1:0] pack_model();
    logic [CW-1:0] v;
    v = '0;
    for (int i = 0; i < SC; i++) v[i*SW +: SW] = SW'(m_cnt[i]);
    return v;
  endfunction

  // Compare DUT outputs against the model while current inputs are applied.
  task automatic check_outputs();
    logic [CW:0]   e;
    logic [SC-1:0] ez;
    logic [SC-1:0] em;
    bit            all_t;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
      e = {1'b0, pack_model()};
    end else begin
      e = exp_q.pop_front();
    end
    check("count", 32'(count), 32'(e[CW-1:0]));
    check("wrap_pulse", 32'(wrap_pulse), 32'(e[CW]));
    all_t = 1'b1;
    for (int i = 0; i < SC; i++) begin
      ez[i] = (m_cnt[i] == 0);
      em[i] = (m_cnt[i] >= max_of(i));
      all_t = all_t & term_of(i);
    end
    check("is_zero", 32'(is_zero), 32'(ez));
    check("is_max", 32'(is_max), 32'(em));
    check("carry_out", 32'(carry_out), 32'(step & all_t));
  endtask

  // Advance the model by the clock edge that consumes the current inputs.
  task automatic model_update();
    int  nxt[SC];
    bit  t[SC];
    bit  all_t;
    bit  c;
    logic wrap_n;
    all_t = 1'b1;
    for (int i = 0; i < SC; i++) begin
      t[i]   = term_of(i);
      all_t  = all_t & t[i];
      nxt[i] = m_cnt[i];
    end
    wrap_n = step & all_t & ~clear & ~load;
    if (clear) begin
      for (int i = 0; i < SC; i++) nxt[i] = 0;
    end else if (load) begin
      for (int i = 0; i < SC; i++) nxt[i] = int'(load_value[i*SW +: SW]);
    end else if (step && !(SAT && all_t)) begin
      c = 1'b1;
      for (int i = 0; i < SC; i++) begin
        if (c) begin
          if (down) nxt[i] = t[i] ? max_of(i) : (m_cnt[i] - 1) & 15;
          else      nxt[i] = t[i] ? 0 : (m_cnt[i] + 1) & 15;
        end
        c = c & t[i];
      end
    end
    for (int i = 0; i < SC; i++) m_cnt[i] = nxt[i];
    exp_q.push_back({wrap_n, pack_model()});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic s, input logic d, input logic c, input logic l,
                       input logic [CW-1:0] lv, input logic [CW-1:0] mx);
    @(negedge clock);
    step = s; down = d; clear = c; load = l; load_value = lv; count_max = mx;
    #1;
    check_outputs();
    model_update();
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset();
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_wrap", 32'(wrap_pulse), 32'd0);
    check("rst_is_zero", 32'(is_zero), 32'h7);
    for (int i = 0; i < SC; i++) m_cnt[i] = 0;
    exp_q.delete();
    exp_q.push_back('0);
    step = 1'b0; down = 1'b0; clear = 1'b0; load = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  localparam logic [CW-1:0] MX_BASE = {4'd1, 4'd2, 4'd3};

  initial begin
    reset_n = 1'b0; step = 1'b0; down = 1'b0; clear = 1'b0; load = 1'b0;
    load_value = '0; count_max = MX_BASE;
    for (int i = 0; i < SC; i++) m_cnt[i] = 0;
    exp_q.push_back('0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Mixed-radix walk through all 24 states and back to zero.
    for (int k = 0; k < 24; k++) cycle(1, 0, 0, 0, '0, MX_BASE);
    @(posedge clock); #1;
    check("walk_end_count", 32'(count), 32'd0);
    check("walk_end_wrap", 32'(wrap_pulse), 32'd1);
    cycle(0, 0, 0, 0, '0, MX_BASE);

    // Down-step from zero wraps to all maxima.
    async_reset();
    cycle(1, 1, 0, 0, '0, MX_BASE);
    @(posedge clock); #1;
    check("down_wrap_count", 32'(count), 32'h123);
    check("down_wrap_pulse", 32'(wrap_pulse), 32'd1);
    cycle(0, 0, 0, 0, '0, MX_BASE);

    // Load wins over step; clear wins over load.
    cycle(1, 0, 0, 1, {4'd0, 4'd1, 4'd2}, MX_BASE);
    @(posedge clock); #1;
    check("load_count", 32'(count), 32'h012);
    cycle(1, 0, 1, 1, {4'd3, 4'd3, 4'd3}, MX_BASE);
    @(posedge clock); #1;
    check("clear_count", 32'(count), 32'd0);

    // Stage 1 max of zero passes carries straight through.
    for (int k = 0; k < 10; k++) cycle(1, 0, 0, 0, '0, {4'd1, 4'd0, 4'd3});
    cycle(0, 0, 1, 0, '0, MX_BASE);

    // Lowering max below the current count makes the stage terminal.
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, '0, MX_BASE);
    cycle(1, 0, 0, 0, '0, {4'd1, 4'd2, 4'd1});
    @(posedge clock); #1;
    check("max_lowered", 32'(count), 32'h010);
    cycle(1, 0, 0, 0, '0, MX_BASE);
    async_reset();

    // 30 up-steps from zero; with saturation the chain sticks at its maxima.
    for (int k = 0; k < 30; k++) cycle(1, 0, 0, 0, '0, MX_BASE);
`ifdef CASCADE_COUNTER_CHAIN_SATURATE_EN
    @(posedge clock); #1;
    check("sat_stick", 32'(count), 32'h123);
    cycle(1, 1, 0, 0, '0, MX_BASE);
    @(posedge clock); #1;
    check("sat_leave", 32'(count), 32'h122);
`endif
    cycle(0, 0, 1, 0, '0, MX_BASE);

    // Randomised traffic, including runtime max changes and oversized loads.
    begin
      logic [CW-1:0] mx;
      mx = MX_BASE;
      for (int k = 0; k < 600; k++) begin
        if ($urandom_range(0, 19) == 0) begin
          for (int i = 0; i < SC; i++) mx[i*SW +: SW] = SW'($urandom_range(0, 5));
        end
        cycle(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
              ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
              CW'($urandom), mx);
        if (k == 300) async_reset();
      end
    end
    cycle(0, 0, 0, 0, '0, MX_BASE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
